// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and types for the button/rhythm datapath
// Purpose: debounce FSM state encoding and debounce length defaults.
// Ports: none (package).
package game_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_CONFIRM   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_CONFIRM = 2'd3
    } deb_state_t;

    // 10 ms at 50 MHz for hardware; a short value keeps simulations fast.
    localparam int DEBOUNCE_CYCLES_50M = 500000;
    localparam int SIM_DEBOUNCE        = 4;

endpackage

// File: rtl/hit_conditioner_if.sv
// rtl/hit_conditioner_if.sv - button/hit signal bundle between GPIO side and datapath
// Purpose: groups the hit_conditioner stimulus and result signals.
// Ports (signals):
//   btn_n, arm, tick            driven by master (GPIO / control side)
//   btn_level, press_pulse,
//   hit_n, drop_count           driven by slave (hit_conditioner)
interface hit_conditioner_if #(
    parameter int DROP_W = 8
);
    logic              btn_n;
    logic              arm;
    logic              tick;
    logic              btn_level;
    logic              press_pulse;
    logic              hit_n;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output btn_n, arm, tick,
        input  btn_level, press_pulse, hit_n, drop_count
    );

    modport slave (
        input  btn_n, arm, tick,
        output btn_level, press_pulse, hit_n, drop_count
    );
endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for a single asynchronous input
// Purpose: brings an asynchronous 1-bit input into the clk domain.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous reset, active-low; all stages load RESET_VAL
//   d_i  in   asynchronous input
//   q_o  out  synchronised output, STAGES cycles behind d_i
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/hit_conditioner.sv
// rtl/hit_conditioner.sv - debounces the push button and turns presses into held hit requests
// Purpose: synchronise + debounce btn_n, pulse once per press, hold hit_n low
//          until the next shift tick consumes it, count presses that overrun.
// Ports:
//   clk  in   50 MHz system clock
//   rst  in   synchronous reset, active-low
//   bus  slave modport of hit_conditioner_if:
//        btn_n in (raw, active-low), arm in, tick in,
//        btn_level out, press_pulse out, hit_n out, drop_count out
module hit_conditioner
    import game_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int CNT_W           = 19,
    parameter int DROP_W          = 8
) (
    input  logic          clk,
    input  logic          rst,
    hit_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic              btn_sync_n;
    logic              pressed_s;
    deb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              btn_level_q, btn_level_d;
    logic              press_pulse_q, press_pulse_d;
    logic              pending_q, pending_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              set_ev;

    // Released level (1) on reset so a held button is not seen as a press edge.
    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.btn_n),
        .q_o (btn_sync_n)
    );

    assign pressed_s = ~btn_sync_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RELEASED;
            cnt_q         <= '0;
            btn_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
            pending_q     <= 1'b0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_level_q   <= btn_level_d;
            press_pulse_q <= press_pulse_d;
            pending_q     <= pending_d;
            drop_q        <= drop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (pressed_s) begin
                    state_d = PRESS_CONFIRM;
                    cnt_d   = '0;
                end
            end
            PRESS_CONFIRM: begin
                if (!pressed_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRESSED;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_CONFIRM;
                    cnt_d   = '0;
                end
            end
            RELEASE_CONFIRM: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_CONFIRM);
    end

    // The datapath samples hit_n during the tick cycle, so clearing on that
    // edge still lets the tick see the request; a new set beats the clear.
    always_comb begin
        set_ev    = press_pulse_q && bus.arm;
        pending_d = pending_q;
        drop_d    = drop_q;
        if (!bus.arm) begin
            pending_d = 1'b0;
        end else if (set_ev) begin
            pending_d = 1'b1;
            if (pending_q && !bus.tick && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (bus.tick && pending_q) begin
            pending_d = 1'b0;
        end
    end

    assign bus.btn_level   = btn_level_q;
    assign bus.press_pulse = press_pulse_q;
    assign bus.hit_n       = ~pending_q;
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_hit_conditioner.sv
// tb/tb_hit_conditioner.sv - self-checking bench for hit_conditioner
module tb_hit_conditioner;
    import game_pkg::*;

    localparam int SYNC   = 2;
    localparam int DC     = SIM_DEBOUNCE;
    localparam int CNT_W  = 3;
    localparam int DROP_W = 8;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    hit_conditioner_if #(.DROP_W(DROP_W)) bus();

    hit_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CNT_W),
        .DROP_W          (DROP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pressed-level delay line, run length of samples that
    // disagree with the debounced level, and the hit/overrun bookkeeping.
    bit m_sh [SYNC];
    bit m_level, m_pulse, m_pending;
    int m_run, m_drop;

    task automatic model_update(input logic b, input logic a, input logic t, input logic r);
        bit s;
        if (!r) begin
            for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
            m_level = 0; m_pulse = 0; m_pending = 0; m_run = 0; m_drop = 0;
        end else begin
            s = m_sh[SYNC-1];
            if (!a) m_pending = 0;
            else if (m_pulse) begin
                if (m_pending && !t && m_drop < DMAX) m_drop++;
                m_pending = 1;
            end else if (t) m_pending = 0;
            if (s != m_level) begin
                m_run++;
                // a level change needs DC+1 consecutive disagreeing samples
                if (m_run == DC + 1) begin
                    m_level = s; m_pulse = s; m_run = 0;
                end else m_pulse = 0;
            end else begin
                m_run = 0; m_pulse = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = ~b;
        end
    endtask

    task automatic step(input logic b, input logic a, input logic t, input logic r);
        rst = r; bus.btn_n = b; bus.arm = a; bus.tick = t;
        @(posedge clk);
        model_update(b, a, t, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_release(input logic a);
        for (int i = 0; i < 8; i++) step(1'b0, a, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, a, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        int first, npulse;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL reset_level: got %b want 0", bus.btn_level); end
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL reset_hit_n: got %b want 1", bus.hit_n); end
        total++; if (bus.drop_count !== '0) begin bad++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
        total++; if (bus.press_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", bus.press_pulse); end
        first = -1; npulse = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.press_pulse === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
            end
            if (k == 7) begin
                total++; if (bus.hit_n !== 1'b0) begin bad++; $display("FAIL reset_first_hit: got %b want 0", bus.hit_n); end
            end
        end
        total++; if (first != 6) begin bad++; $display("FAIL latency: got cycle %0d want 6", first); end
        total++; if (npulse != 1) begin bad++; $display("FAIL pulse_count: got %0d want 1", npulse); end
    endtask

    task automatic test_bounce();
        logic pat [6];
        int npulse, nlevel, first;
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        npulse = 0; nlevel = 0;
        for (int k = 0; k < 26; k++) begin
            step((k < 6) ? pat[k] : 1'b1, 1'b1, 1'b0, 1'b1);
            if (bus.press_pulse === 1'b1) npulse++;
            if (bus.btn_level !== 1'b0) nlevel++;
        end
        total++; if (npulse != 0) begin bad++; $display("FAIL bounce_pulse: got %0d want 0", npulse); end
        total++; if (nlevel != 0) begin bad++; $display("FAIL bounce_level: got %0d cycles high want 0", nlevel); end
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL bounce_hit_n: got %b want 1", bus.hit_n); end
        first = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.press_pulse === 1'b1 && first < 0) first = k;
        end
        total++; if (first != 6) begin bad++; $display("FAIL bounce_recover: got cycle %0d want 6", first); end
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL bounce_release: got %b want 0", bus.btn_level); end
    endtask

    task automatic test_handshake();
        int nlow, npulse;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (k == 6) begin
                total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL hs_pulse_cycle_hit: got %b want 1", bus.hit_n); end
            end
        end
        total++; if (bus.hit_n !== 1'b0) begin bad++; $display("FAIL hs_hit_after_pulse: got %b want 0", bus.hit_n); end
        nlow = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.hit_n === 1'b0) nlow++;
        end
        total++; if (nlow != 20) begin bad++; $display("FAIL hs_hold: got %0d low cycles want 20", nlow); end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL hs_clear: got %b want 1", bus.hit_n); end
        npulse = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.press_pulse === 1'b1) npulse++;
        end
        total++; if (npulse != 0) begin bad++; $display("FAIL hs_held_pulses: got %0d want 0", npulse); end
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL hs_held_hit: got %b want 1", bus.hit_n); end
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_coincidence();
        int nlow;
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        total++; if (bus.press_pulse !== 1'b1) begin bad++; $display("FAIL co_pulse: got %b want 1", bus.press_pulse); end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        total++; if (bus.hit_n !== 1'b0) begin bad++; $display("FAIL co_set_wins: got %b want 0", bus.hit_n); end
        nlow = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (bus.hit_n === 1'b0) nlow++;
        end
        total++; if (nlow != 10) begin bad++; $display("FAIL co_hold: got %0d low cycles want 10", nlow); end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL co_next_tick: got %b want 1", bus.hit_n); end
    endtask

    task automatic test_overrun();
        do_reset();
        press_release(1'b1);
        total++; if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL ov_first: got %0d want 0", bus.drop_count); end
        press_release(1'b1);
        total++; if (bus.drop_count !== 8'd1) begin bad++; $display("FAIL ov_one: got %0d want 1", bus.drop_count); end
        total++; if (bus.hit_n !== 1'b0) begin bad++; $display("FAIL ov_hit: got %b want 0", bus.hit_n); end
        for (int i = 0; i < 300; i++) press_release(1'b1);
        total++; if (bus.drop_count !== 8'd255) begin bad++; $display("FAIL ov_saturate: got %0d want 255", bus.drop_count); end
        total++; if (bus.hit_n !== 1'b0) begin bad++; $display("FAIL ov_hit_sat: got %b want 0", bus.hit_n); end
    endtask

    task automatic test_arm_reset();
        int npulse, nhigh;
        do_reset();
        press_release(1'b1);
        press_release(1'b1);
        total++; if (bus.hit_n !== 1'b0) begin bad++; $display("FAIL ar_pending: got %b want 0", bus.hit_n); end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL ar_disarm: got %b want 1", bus.hit_n); end
        npulse = 0; nhigh = 0;
        for (int k = 0; k < 16; k++) begin
            step((k < 8) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b1);
            if (bus.press_pulse === 1'b1) npulse++;
            if (bus.hit_n === 1'b1) nhigh++;
        end
        total++; if (npulse != 1) begin bad++; $display("FAIL ar_disarmed_pulse: got %0d want 1", npulse); end
        total++; if (nhigh != 16) begin bad++; $display("FAIL ar_disarmed_hit: got %0d high cycles want 16", nhigh); end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.drop_count !== '0) begin bad++; $display("FAIL ar_rst_drop: got %0d want 0", bus.drop_count); end
        total++; if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL ar_rst_level: got %b want 0", bus.btn_level); end
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (bus.press_pulse === 1'b1) npulse++;
        end
        total++; if (npulse != 0) begin bad++; $display("FAIL ar_rst_residual: got %0d want 0", npulse); end
        total++; if (bus.hit_n !== 1'b1) begin bad++; $display("FAIL ar_rst_hit: got %b want 1", bus.hit_n); end
    endtask

    task automatic test_random();
        logic b, a, t, r;
        int left;
        do_reset();
        b = 1'b1; a = 1'b1; left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (left == 0) begin
                b = ~b;
                left = $urandom_range(1, 12);
            end
            left--;
            if ($urandom_range(0, 199) == 0) a = ~a;
            t = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 499) != 0);
            step(b, a, t, r);
            total++; if (bus.btn_level !== m_level) begin bad++; $display("FAIL rnd_level c=%0d: got %b want %b", c, bus.btn_level, m_level); end
            total++; if (bus.press_pulse !== m_pulse) begin bad++; $display("FAIL rnd_pulse c=%0d: got %b want %b", c, bus.press_pulse, m_pulse); end
            total++; if (bus.hit_n !== !m_pending) begin bad++; $display("FAIL rnd_hit_n c=%0d: got %b want %b", c, bus.hit_n, !m_pending); end
            total++; if (bus.drop_count !== DROP_W'(m_drop)) begin bad++; $display("FAIL rnd_drop c=%0d: got %0d want %0d", c, bus.drop_count, m_drop); end
        end
    endtask

    initial begin
        rst = 1'b0; bus.btn_n = 1'b1; bus.arm = 1'b1; bus.tick = 1'b0;
        test_reset();
        test_bounce();
        test_handshake();
        test_coincidence();
        test_overrun();
        test_arm_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hit_conditioner.md
Name: hit_conditioner

Overview:
- Sits between the raw GPIO push button and the rhythm datapath, on the 50 MHz domain.
- Synchronises and debounces the active-low button, then converts each clean press into one hit request.
- The request is held low on hit_n until the next 8 Hz shift tick has sampled it, so each physical press is judged exactly once.
- Reports presses that arrive while a previous hit is still unconsumed, via an overrun counter.

Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz).
- CNT_W, 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DROP_W, 8: overrun counter width.

Ports:
- clk  input  1  50 MHz system clock
- rst  input  1  synchronous reset, active-low
- btn_n  input  1  raw push button, active-low, asynchronous to clk
- arm  input  1  1 = gameplay active (driven by the control FSM shift-enable); 0 = presses ignored
- tick  input  1  one-clk-cycle strobe marking each 8 Hz shift edge of the datapath
- btn_level  output  1  debounced button level, 1 = pressed
- press_pulse  output  1  one-cycle strobe on each accepted press
- hit_n  output  1  active-low hit request presented to the datapath button input
- drop_count  output  DROP_W  saturating count of overrun presses

Behaviour:
- Reset (rst=0 at posedge clk):
  - Synchroniser flops load 1 (released); FSM goes to RELEASED; debounce counter = 0.
  - btn_level=0, press_pulse=0, pending=0, hit_n=1, drop_count=0.
  - Reset applies mid-debounce or mid-pending with no residual event.
- Synchroniser: btn_n passes through SYNC_STAGES flops. s = inverted synchroniser output (1 = pressed).
- Debounce FSM has four states:
  - RELEASED: s=1 -> PRESS_CONFIRM, counter=0.
  - PRESS_CONFIRM: s=0 -> RELEASED, counter=0. While s=1, counter increments. When counter = DEBOUNCE_CYCLES-1 and s=1 -> PRESSED.
  - PRESSED: s=0 -> RELEASE_CONFIRM, counter=0.
  - RELEASE_CONFIRM: s=1 -> PRESSED, counter=0. While s=0, counter increments. When counter = DEBOUNCE_CYCLES-1 and s=0 -> RELEASED.
- Outputs and latency:
  - btn_level = 1 in PRESSED and RELEASE_CONFIRM, registered.
  - press_pulse = 1 for exactly the first cycle in PRESSED after PRESS_CONFIRM.
  - Latency: raw edge to btn_level/press_pulse rise = SYNC_STAGES + DEBOUNCE_CYCLES clk cycles.
  - Holding the button produces no further pulses. A glitch shorter than DEBOUNCE_CYCLES produces nothing.
- Pending/handshake (pending is a register; hit_n = ~pending):
  - Set event: press_pulse && arm.
  - Clear event: tick && pending. The datapath samples hit_n at the start of the tick cycle, so clear takes effect the cycle after tick.
  - Set and clear in the same cycle: set wins, pending stays 1 and is offered to the next tick.
  - arm=0: pending is forced to 0 next cycle and set events are ignored; btn_level and press_pulse still operate.
- Overrun:
  - Set event while pending=1 and no tick that cycle: drop_count increments, pending unchanged.
  - Saturates at 2^DROP_W-1; no wrap.
- Counter arithmetic: the debounce counter is unsigned CNT_W bits and never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package (game_pkg) holds:
  - Debounce FSM state localparams: RELEASED=2'd0, PRESS_CONFIRM=2'd1, PRESSED=2'd2, RELEASE_CONFIRM=2'd3.
  - Defaults DEBOUNCE_CYCLES_50M=500000 and SIM_DEBOUNCE=4.
- One sub-module: sync_chain (parameter STAGES and reset value, 1-bit input, 1-bit output), reused for any later GPIO inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, arm=1 unless stated):
1. Reset: hold rst=0 with btn_n=0 -> btn_level=0, hit_n=1, drop_count=0; after rst=1 and btn_n=0 from cycle 0 -> press_pulse high exactly at cycle 6 for 1 cycle.
2. Bounce: btn_n low 3 cycles, high 1, low 2, high -> no press_pulse, btn_level stays 0, FSM returns to RELEASED.
3. Handshake: clean press -> hit_n=0 from the cycle after press_pulse. tick strobed 20 cycles later -> hit_n=1 exactly one cycle after the tick cycle. Holding btn_n low 100 more cycles -> no new pulse.
4. Coincidence: press_pulse in the same cycle as tick with pending=0 -> hit_n goes 0 and stays 0 until the following tick.
5. Overrun: two clean presses (release debounced between them) with no tick -> drop_count=1, hit_n stays 0. Force 300 overruns with DROP_W=8 -> drop_count=255.
6. Arm/reset mid-operation: pending=1, drop arm to 0 -> hit_n=1 next cycle, and a press while arm=0 leaves hit_n=1. Assert rst=0 during PRESS_CONFIRM -> all outputs return to reset values, no press_pulse afterwards.
